// File: rtl/fetch_unit.sv
// Instruction fetch unit for the 16-bit WISC core. It owns the PC, fetches words over
// a req/ack handshake, presents them to decode via valid/ready and applies redirects.
module fetch_unit #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic [PC_W-1:0] instr,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] instr_pc,
    output logic [PC_W-1:0] instr_pc1,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halted,
    output logic [15:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [3:0] OP_HLT = 4'hF;

    state_t          state;
    state_t          nextState;
    logic [PC_W-1:0] pc;
    logic            pendV;
    logic [PC_W-1:0] pendPc;
    logic [PC_W-1:0] instrReg;
    logic [PC_W-1:0] instrPcReg;
    logic [15:0]     fetchCnt;
    logic            holdAccept;
    logic            isHlt;

    assign holdAccept = (state == HOLD) && instr_ready;
    assign isHlt      = (instrReg[PC_W-1 -: 4] == OP_HLT);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a redirect always wins over halt and normal advance.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: nextState = REQ;
            REQ: begin
                if (imem_ack && !pendV && !redirect_valid) begin
                    nextState = HOLD;
                end else begin
                    nextState = REQ;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    nextState = REQ;
                end else if (holdAccept) begin
                    nextState = isHlt ? HALTED : REQ;
                end else begin
                    nextState = HOLD;
                end
            end
            HALTED:  nextState = HALTED;
            default: nextState = IDLE;
        endcase
    end

    // Output decode from registered state only.
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            REQ:     imem_req    = 1'b1;
            HOLD:    instr_valid = 1'b1;
            HALTED:  halted      = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
                halted      = 1'b0;
            end
        endcase
    end

    // PC, pending redirect, presented instruction and accept counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            pendV      <= 1'b0;
            pendPc     <= {PC_W{1'b0}};
            instrReg   <= {PC_W{1'b0}};
            instrPcReg <= {PC_W{1'b0}};
            fetchCnt   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    pendV <= 1'b0;
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else begin
                        pc <= pc;
                    end
                end
                REQ: begin
                    // The address may only move once the outstanding request completes.
                    if (imem_ack) begin
                        if (pendV || redirect_valid) begin
                            pc    <= redirect_valid ? redirect_pc : pendPc;
                            pendV <= 1'b0;
                        end else begin
                            instrReg   <= imem_rdata;
                            instrPcReg <= pc;
                        end
                    end else if (redirect_valid) begin
                        pendV  <= 1'b1;
                        pendPc <= redirect_pc;
                    end else begin
                        pendV <= pendV;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (holdAccept) begin
                        fetchCnt <= fetchCnt + 16'd1;
                        if (!isHlt) begin
                            pc <= pc + {{(PC_W-1){1'b0}}, 1'b1};
                        end else begin
                            pc <= pc;
                        end
                    end else begin
                        pc <= pc;
                    end
                end
                default: begin
                    pc <= pc;
                end
            endcase
        end
    end

    assign imem_addr = pc;
    assign instr     = instrReg;
    assign opcode    = instrReg[PC_W-1 -: 4];
    assign instr_pc  = instrPcReg;
    assign instr_pc1 = instrPcReg + {{(PC_W-1){1'b0}}, 1'b1};
    assign fetch_cnt = fetchCnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a transaction-level model of the fetch rules.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rstN, ack, ready, redir;
    logic [15:0] rdata, rpc;
    logic        req, valid, halted;
    logic [15:0] addr, instr, instrPc, instrPc1, cnt;
    logic [3:0]  opcode;

    int          nCompared = 0;
    int          nMismatch = 0;
    bit          checkEn   = 1'b0;
    bit          forceData = 1'b0;
    logic [15:0] haltAddr  = 16'h0007;

    // Model: what fetch is doing, expressed as flags plus the architectural values.
    bit          mReq, mValid, mHalted, mPendV;
    logic [15:0] mPc, mPendPc, mInstr, mInstrPc, mCnt;

    fetch_unit #(.PC_W(16), .RESET_PC(16'h0010)) dut (
        .clk(clk), .rst_n(rstN),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .instr(instr), .opcode(opcode), .instr_pc(instrPc), .instr_pc1(instrPc1),
        .instr_valid(valid), .instr_ready(ready),
        .redirect_valid(redir), .redirect_pc(rpc),
        .halted(halted), .fetch_cnt(cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        logic [15:0] w;
        w = (a * 16'h03A5) ^ 16'h1234;
        if (w[15:12] == 4'hF) w[15:12] = 4'hE;
        if (a == haltAddr) w = 16'hF000;
        return w;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update on each rising edge from the same input values the DUT sees.
    always @(posedge clk) begin
        if (!rstN) begin
            mReq = 0; mValid = 0; mHalted = 0; mPendV = 0;
            mPc = 16'h0010; mPendPc = 16'h0000; mInstr = 16'h0000; mInstrPc = 16'h0000; mCnt = 16'h0000;
        end else if (mHalted) begin
            mHalted = 1;
        end else if (!mReq && !mValid) begin
            if (redir) mPc = rpc;
            mReq = 1;
        end else if (mReq) begin
            if (ack) begin
                if (redir || mPendV) begin
                    mPc = redir ? rpc : mPendPc;
                    mPendV = 0;
                end else begin
                    mInstr = rdata; mInstrPc = mPc; mReq = 0; mValid = 1;
                end
            end else if (redir) begin
                mPendV = 1; mPendPc = rpc;
            end
        end else begin
            if (redir) begin
                mPc = rpc; mValid = 0; mReq = 1;
            end else if (ready) begin
                mCnt = mCnt + 16'd1;
                mValid = 0;
                if (mInstr[15:12] == 4'hF) mHalted = 1;
                else begin mPc = mPc + 16'd1; mReq = 1; end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            cmp("imem_req", {15'd0, req}, {15'd0, mReq});
            cmp("imem_addr", addr, mPc);
            cmp("instr_valid", {15'd0, valid}, {15'd0, mValid});
            cmp("halted", {15'd0, halted}, {15'd0, mHalted});
            cmp("instr", instr, mInstr);
            cmp("opcode", {12'd0, opcode}, {12'd0, mInstr[15:12]});
            cmp("instr_pc", instrPc, mInstrPc);
            cmp("instr_pc1", instrPc1, mInstrPc + 16'd1);
            cmp("fetch_cnt", cnt, mCnt);
        end
    end

    task automatic tick();
        if (!forceData) rdata = memWord(addr);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rstN = 1'b0; ack = 1'b0; ready = 1'b0; redir = 1'b0; rpc = 16'h0000; rdata = 16'h0000;
        @(posedge clk);
        #1 checkEn = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) tick();
        cmp("lit_rst_req", {15'd0, req}, 16'd0);
        cmp("lit_rst_valid", {15'd0, valid}, 16'd0);
        cmp("lit_rst_halted", {15'd0, halted}, 16'd0);
        cmp("lit_rst_addr", addr, 16'h0010);
        cmp("lit_rst_cnt", cnt, 16'h0000);

        // Zero-wait streaming from RESET_PC.
        rstN = 1'b1; ack = 1'b1; ready = 1'b1;
        tick();
        cmp("lit_first_req", {15'd0, req}, 16'd1);
        cmp("lit_first_addr", addr, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("lit_stream_valid", {15'd0, valid}, 16'd1);
            cmp("lit_stream_pc", instrPc, 16'h0010 + 16'(i));
            tick();
            cmp("lit_stream_addr", addr, 16'h0011 + 16'(i));
            cmp("lit_stream_cnt", cnt, 16'(i + 1));
        end

        // Late ack.
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("lit_wait_req", {15'd0, req}, 16'd1);
            cmp("lit_wait_addr", addr, 16'h0013);
        end
        ack = 1'b1;
        tick();
        cmp("lit_late_valid", {15'd0, valid}, 16'd1);
        cmp("lit_late_pc", instrPc, 16'h0013);

        // Decode stall.
        ready = 1'b0; ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cmp("lit_stall_pc", instrPc, 16'h0013);
            cmp("lit_stall_req", {15'd0, req}, 16'd0);
        end
        ready = 1'b1;
        tick();
        cmp("lit_release_addr", addr, 16'h0014);
        cmp("lit_release_cnt", cnt, 16'd4);

        // Redirect while a request is outstanding, then stale ack.
        redir = 1'b1; rpc = 16'h0200;
        tick();
        cmp("lit_pend_addr", addr, 16'h0014);
        redir = 1'b0; forceData = 1'b1; rdata = 16'hABCD; ack = 1'b1;
        tick();
        cmp("lit_discard_valid", {15'd0, valid}, 16'd0);
        cmp("lit_redirect_addr", addr, 16'h0200);
        forceData = 1'b0;
        tick();
        cmp("lit_redirect_pc", instrPc, 16'h0200);

        // Redirect in HOLD with ready high.
        redir = 1'b1; rpc = 16'h0040;
        tick();
        cmp("lit_hold_redir_valid", {15'd0, valid}, 16'd0);
        cmp("lit_hold_redir_cnt", cnt, 16'd4);
        cmp("lit_hold_redir_addr", addr, 16'h0040);

        // Halt at 0x0007.
        rpc = 16'h0007;
        tick();
        cmp("lit_to7_addr", addr, 16'h0007);
        redir = 1'b0;
        tick();
        cmp("lit_hlt_instr", instr, 16'hF000);
        cmp("lit_hlt_opcode", {12'd0, opcode}, 16'h000F);
        tick();
        cmp("lit_halted", {15'd0, halted}, 16'd1);
        cmp("lit_halted_cnt", cnt, 16'd5);
        redir = 1'b1; rpc = 16'h0123;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("lit_halt_hold", {15'd0, halted}, 16'd1);
            cmp("lit_halt_noreq", {15'd0, req}, 16'd0);
            cmp("lit_halt_addr", addr, 16'h0007);
        end
        rstN = 1'b0; redir = 1'b0;
        tick();
        cmp("lit_unhalt", {15'd0, halted}, 16'd0);
        cmp("lit_unhalt_addr", addr, 16'h0010);
        rstN = 1'b1;
        tick();
        cmp("lit_resume_req", {15'd0, req}, 16'd1);

        // PC wrap.
        redir = 1'b1; rpc = 16'hFFFF;
        tick();
        cmp("lit_wrap_from", addr, 16'hFFFF);
        redir = 1'b0;
        tick();
        cmp("lit_wrap_pc1", instrPc1, 16'h0000);
        tick();
        cmp("lit_wrap_addr", addr, 16'h0000);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            ack   = ($urandom_range(2) != 0);
            ready = ($urandom_range(3) != 0);
            redir = ($urandom_range(9) == 0);
            rpc   = ($urandom_range(7) == 0) ? 16'hFFFD + 16'($urandom_range(2)) : 16'($urandom_range(63));
            rstN  = ($urandom_range(99) != 0) && !(halted && $urandom_range(7) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the 16-bit WISC core. It owns the PC, requests instruction words from instruction memory over a req/ack handshake, and presents each word to decode through a valid/ready handshake; decode's `opcode` output feeds the control decoder. It applies branch and jump redirects from execute. When a HLT (4'b1111) instruction is accepted by decode, it enters a terminal halted state.

## Interface
- `PC_W`, 16: PC, address and instruction width.
- `RESET_PC`, 16'h0000: PC value loaded on reset.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `imem_req` out 1: fetch request; high only in state REQ.
- `imem_addr` out PC_W: fetch address, equal to `pc`; stable while `imem_req` is high.
- `imem_ack` in 1: memory returns data this cycle; ignored when `imem_req`=0.
- `imem_rdata` in PC_W: instruction word, valid only when `imem_ack`=1.
- `instr` out PC_W: registered instruction word presented to decode.
- `opcode` out 4: `instr[15:12]`, to the control decoder.
- `instr_pc` out PC_W: address of `instr`.
- `instr_pc1` out PC_W: `instr_pc`+1, mod 2^PC_W; used as the JAL link value.
- `instr_valid` out 1: `instr` is valid; high only in state HOLD.
- `instr_ready` in 1: decode accepts `instr` this cycle.
- `redirect_valid` in 1: a taken branch, JAL or JR from an older instruction.
- `redirect_pc` in PC_W: redirect target.
- `halted` out 1: a HLT instruction has been accepted.
- `fetch_cnt` out 16: count of accepted instructions; wraps from 16'hFFFF to 0.

## Operation
- States:
  - IDLE: reset state.
  - REQ: a request is outstanding.
  - HOLD: an instruction is presented to decode.
  - HALTED: terminal.
- Accept: `instr_valid` & `instr_ready` in the same cycle.
- IDLE -> REQ unconditionally on the next edge. If `redirect_valid`=1 in IDLE, `pc` <= `redirect_pc`.
- REQ, with `imem_ack`=1 and no redirect pending:
  - `instr` <= `imem_rdata`, `instr_pc` <= `pc`.
  - Go to HOLD.
- REQ, with `redirect_valid`=1 and `imem_ack`=0:
  - Set `pend_v`=1, `pend_pc` <= `redirect_pc`.
  - Stay in REQ with `imem_addr` unchanged; the protocol forbids changing the address mid-request.
  - A later redirect overwrites `pend_pc`.
- REQ, with `imem_ack`=1 and (`pend_v`=1 or `redirect_valid`=1):
  - Discard the data.
  - `pc` <= `redirect_pc` if `redirect_valid`=1, else `pend_pc`.
  - Clear `pend_v` and stay in REQ; the new address appears on the next cycle.
- HOLD, with `redirect_valid`=1: drop `instr_valid`, `pc` <= `redirect_pc`, go to REQ. `fetch_cnt` is unchanged, even if `instr_ready`=1.
- HOLD, on accept with `opcode` != 4'hF: `pc` <= `pc`+1, `fetch_cnt`++, go to REQ.
- HOLD, on accept with `opcode` == 4'hF: `fetch_cnt`++, `pc` is held, go to HALTED.
- HOLD, with `instr_ready`=0: hold `instr` and all outputs stable.
- HALTED: `imem_req`=0, `instr_valid`=0, `halted`=1. All inputs are ignored; only reset exits this state.
- Priority: reset > redirect > halt > normal advance.
- Arithmetic: `pc`+1 and `fetch_cnt`+1 wrap modulo 2^width, with no flags.

## Timing
- Reset values: state IDLE, `pc`=RESET_PC, `pend_v`=0, `instr`=0, `instr_pc`=0, `fetch_cnt`=0.
- Outputs during and right after reset: `imem_req`=0, `instr_valid`=0, `halted`=0, `imem_addr`=RESET_PC.
- First `imem_req`: in the second cycle after `rst_n` rises.
- Latency: `imem_ack` in cycle N gives `instr_valid` in cycle N+1.
- Accept in cycle M gives `imem_req` with the next address in cycle M+1.
- Peak throughput with zero-wait memory and `instr_ready` tied high: one instruction per 2 cycles.
- `imem_req`, `instr_valid` and `halted` are decoded from registered state only. There is no combinational path from any input to any output.
- Reset asserted in any state, including REQ with a request outstanding: return to IDLE on that edge. An `imem_ack` in the same cycle is discarded.

## Test plan
- Reset with RESET_PC=16'h0010, zero-wait memory, `instr_ready`=1 -> `imem_addr` sequence 0x10, 0x11, 0x12 on alternating cycles, and `fetch_cnt` counts 1, 2, 3.
- Memory acks 3 cycles late -> `imem_addr` and `imem_req` stay stable for 3 cycles, and `instr_valid` rises the cycle after the ack.
- `instr_ready`=0 for 4 cycles in HOLD -> `instr` and `instr_pc` are unchanged and no new request is issued. On release, the next address is `instr_pc`+1.
- Redirect to 0x0200 while in REQ before the ack, then ack with 0xABCD -> 0xABCD is never presented, and the next `imem_addr` is 0x0200.
- Redirect to 0x0040 with `instr_ready`=1 in HOLD -> no accept and `fetch_cnt` unchanged; the next `imem_addr` is 0x0040.
- `instr`=16'hF000 accepted at `pc`=0x0007 -> `halted`=1 from the next cycle and `imem_req` stays 0. A later redirect is ignored. After `rst_n` pulses, fetch resumes at RESET_PC.
- `pc`=16'hFFFF, accept of a non-HLT instruction -> next `imem_addr`=16'h0000.
